// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 16x16 architectural register file with bypassed reads
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        rWrite,
    input  logic [3:0]        op1,
    input  logic [3:0]        op2,
    input  logic [DATA_W-1:0] op1data,
    input  logic [DATA_W-1:0] op2data,
    input  logic [DATA_W-1:0] r15data,
    input  logic [3:0]        rdAddrA,
    input  logic [3:0]        rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic [DATA_W-1:0] r15Out,
    output logic [15:0]       wbCount
);

    localparam logic [3:0] R15 = 4'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic              we1;
    logic              we2;
    logic              we15;

    // op2 is dropped when it aliases op1 so that op1data wins the collision
    assign we1  = (rWrite != 2'b00);
    assign we2  = (rWrite == 2'b11) && (op2 != op1);
    assign we15 = (rWrite == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wbCount <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we15 && (4'(i) == R15)) begin
                    regs[i] <= r15data;
                end else if (we1 && (op1 == 4'(i))) begin
                    regs[i] <= op1data;
                end else if (we2 && (op2 == 4'(i))) begin
                    regs[i] <= op2data;
                end
            end
            if (we1) begin
                wbCount <= wbCount + 16'd1;
            end
        end
    end

    // Bypass priority mirrors the commit priority above
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
        logic [DATA_W-1:0] val;
        val = regs[addr];
        if (we15 && (addr == R15)) begin
            val = r15data;
        end else if (we1 && (addr == op1)) begin
            val = op1data;
        end else if (we2 && (addr == op2)) begin
            val = op2data;
        end
        return val;
    endfunction

    always_comb begin
        rdDataA = '0;
        rdDataB = '0;
        r15Out  = '0;
        if (rst_n) begin
            rdDataA = read_port(rdAddrA);
            rdDataB = read_port(rdAddrB);
            r15Out  = read_port(R15);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
`timescale 1ns/100ps
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rWrite;
    logic [3:0]  op1, op2, rdAddrA, rdAddrB;
    logic [15:0] op1data, op2data, r15data;
    logic [15:0] rdDataA, rdDataB, r15Out, wbCount;

    wb_regfile #(.DATA_W(16), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .rWrite(rWrite), .op1(op1), .op2(op2),
        .op1data(op1data), .op2data(op2data), .r15data(r15data),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA),
        .rdDataB(rdDataB), .r15Out(r15Out), .wbCount(wbCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rw;
        logic [3:0]  a1, a2;
        logic [15:0] d1, d2, d15;
        logic [3:0]  ra, rb;
        logic [15:0] ea, eb, e15, ecnt;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Architectural model: register array plus commit count
    logic [15:0] mreg [16];
    logic [15:0] mnxt [16];
    int          mcnt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] rw, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d15,
                         input logic [3:0] ra, input logic [3:0] rb);
        rWrite = rw; op1 = a1; op2 = a2;
        op1data = d1; op2data = d2; r15data = d15;
        rdAddrA = ra; rdAddrB = rb;
    endtask

    // Register contents after this cycle's writes land; later writes take priority
    task automatic model_next();
        for (int i = 0; i < 16; i++) mnxt[i] = mreg[i];
        if (rWrite == 2'b11) mnxt[op2] = op2data;
        if (rWrite != 2'b00) mnxt[op1] = op1data;
        if (rWrite == 2'b10) mnxt[15] = r15data;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) mreg[i] = mnxt[i];
        if (rWrite != 2'b00) mcnt = (mcnt + 1) % 65536;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
        mcnt = 0;
    endtask

    vec_t tab [12];

    initial begin
        tab[0]  = '{2'b01, 4'h2, 4'h0, 16'h00FF, 16'h0000, 16'h0000, 4'h2, 4'h3, 16'h00FF, 16'h0000, 16'h0000, 16'd0};
        tab[1]  = '{2'b00, 4'h2, 4'h2, 16'h1111, 16'h2222, 16'h3333, 4'h2, 4'h2, 16'h00FF, 16'h00FF, 16'h0000, 16'd1};
        tab[2]  = '{2'b10, 4'h1, 4'h0, 16'hCC00, 16'h0000, 16'h0090, 4'h1, 4'hF, 16'hCC00, 16'h0090, 16'h0090, 16'd1};
        tab[3]  = '{2'b10, 4'hF, 4'h0, 16'hAAAA, 16'h0000, 16'h5555, 4'hF, 4'h1, 16'h5555, 16'hCC00, 16'h5555, 16'd2};
        tab[4]  = '{2'b11, 4'h4, 4'h4, 16'h0031, 16'h0082, 16'h0000, 4'h4, 4'hF, 16'h0031, 16'h5555, 16'h5555, 16'd3};
        tab[5]  = '{2'b00, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h4, 4'h1, 16'h0031, 16'hCC00, 16'h5555, 16'd4};
        tab[6]  = '{2'b11, 4'h4, 4'h5, 16'h0044, 16'h0055, 16'h0000, 4'h4, 4'h5, 16'h0044, 16'h0055, 16'h5555, 16'd4};
        tab[7]  = '{2'b11, 4'hF, 4'h0, 16'hBEEF, 16'h0001, 16'h0000, 4'h0, 4'hF, 16'h0001, 16'hBEEF, 16'hBEEF, 16'd5};
        tab[8]  = '{2'b00, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'hBEEF, 16'h0001, 16'hBEEF, 16'd6};
        tab[9]  = '{2'b11, 4'h3, 4'hF, 16'h1234, 16'h0F0F, 16'h0000, 4'h3, 4'hF, 16'h1234, 16'h0F0F, 16'h0F0F, 16'd6};
        tab[10] = '{2'b01, 4'h0, 4'h0, 16'h7777, 16'h0000, 16'h0000, 4'h0, 4'h2, 16'h7777, 16'h00FF, 16'h0F0F, 16'd7};
        tab[11] = '{2'b00, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h3, 16'h7777, 16'h1234, 16'h0F0F, 16'd8};

        rst_n = 1'b0;
        drive(2'b01, 4'h0, 4'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h0, 4'hF);
        model_clear();
        #3;
        chk("reset rdDataA", rdDataA, 16'h0000);
        chk("reset rdDataB", rdDataB, 16'h0000);
        chk("reset r15Out", r15Out, 16'h0000);
        chk("reset wbCount", wbCount, 16'h0000);
        #4;
        drive(2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            drive(tab[i].rw, tab[i].a1, tab[i].a2, tab[i].d1, tab[i].d2, tab[i].d15, tab[i].ra, tab[i].rb);
            model_next();
            @(negedge clk);
            chk($sformatf("vec%0d rdDataA", i), rdDataA, tab[i].ea);
            chk($sformatf("vec%0d rdDataB", i), rdDataB, tab[i].eb);
            chk($sformatf("vec%0d r15Out", i), r15Out, tab[i].e15);
            chk($sformatf("vec%0d wbCount", i), wbCount, tab[i].ecnt);
            commit();
        end

        // Asynchronous reset between edges, held across one edge with a write pending
        drive(2'b01, 4'h3, 4'h0, 16'hFFFF, 16'h0, 16'h0, 4'h3, 4'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst rdDataA", rdDataA, 16'h0000);
        chk("async rst r15Out", r15Out, 16'h0000);
        chk("async rst wbCount", wbCount, 16'h0000);
        @(posedge clk);
        #1;
        chk("rst held rdDataA", rdDataA, 16'h0000);
        chk("rst held wbCount", wbCount, 16'h0000);
        rWrite = 2'b00;
        rst_n = 1'b1;
        #1;
        chk("post rst reg3", rdDataA, 16'h0000);
        chk("post rst wbCount", wbCount, 16'h0000);
        model_clear();
        @(posedge clk);
        #1;

        // Randomized traffic with frequent address aliasing
        for (int i = 0; i < 300; i++) begin
            logic [3:0] a1, a2;
            a1 = 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) a1 = 4'hF;
            drive(2'($urandom_range(0, 3)), a1, a2, 16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? a1 : 4'($urandom_range(0, 15)));
            model_next();
            @(negedge clk);
            chk("rand rdDataA", rdDataA, mnxt[rdAddrA]);
            chk("rand rdDataB", rdDataB, mnxt[rdAddrB]);
            chk("rand r15Out", r15Out, mnxt[15]);
            chk("rand wbCount", wbCount, 16'(mcnt));
            commit();
        end

        // Mode 00 must ignore all other inputs
        for (int i = 0; i < 10; i++) begin
            drive(2'b00, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom));
            model_next();
            commit();
        end
        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  4'(i), 4'(15 - i));
            model_next();
            @(negedge clk);
            chk($sformatf("idle reg%0d", i), rdDataA, mreg[i]);
            chk($sformatf("idle reg%0d", 15 - i), rdDataB, mreg[15 - i]);
            chk("idle wbCount", wbCount, 16'(mcnt));
            commit();
        end

        // Counter wrap from a fresh reset
        rst_n = 1'b0;
        rWrite = 2'b00;
        #2 rst_n = 1'b1;
        drive(2'b01, 4'h6, 4'h0, 16'hABCD, 16'h0, 16'h0, 4'h6, 4'hF);
        repeat (65535) @(posedge clk);
        #1;
        rWrite = 2'b00;
        @(negedge clk);
        chk("wrap 65535", wbCount, 16'hFFFF);
        chk("wrap reg6", rdDataA, 16'hABCD);
        @(posedge clk);
        #1;
        chk("wrap idle hold", wbCount, 16'hFFFF);
        rWrite = 2'b01;
        @(posedge clk);
        #1;
        rWrite = 2'b00;
        @(negedge clk);
        chk("wrap to zero", wbCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file, directly downstream of the memory/write-back pipeline buffer. Consumes the buffer's registered outputs (write mode, two register specifiers, two data words, R15 data) and commits up to two 16-bit register writes per clock. Provides two combinational read ports with same-cycle write-to-read bypass for the decode stage, plus a dedicated R15 view and a commit counter for debug.

## Interface
- DATA_W, 16, register and data width
- NREGS, 16, register count (addresses 4 bits, R15 = address 4'hF)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- rWrite  in  2  write mode from the buffer: 00 none, 01 op1 only, 10 op1 + R15, 11 op1 + op2
- op1  in  4  destination register for op1data
- op2  in  4  destination register for op2data (mode 11 only)
- op1data  in  16  data for reg[op1]
- op2data  in  16  data for reg[op2]
- r15data  in  16  data for R15 (mode 10 only)
- rdAddrA  in  4  read port A address
- rdAddrB  in  4  read port B address
- rdDataA  out  16  read port A data (combinational, bypassed)
- rdDataB  out  16  read port B data (combinational, bypassed)
- r15Out  out  16  current R15 value (combinational, bypassed)
- wbCount  out  16  count of cycles with rWrite != 00 committed since reset

## Operation
- Register file: 16 x 16-bit flops; no hard-wired registers, R0 is writable.
- Write enables derived from rWrite each cycle:
  - 00: no write; inputs ignored.
  - 01: reg[op1] <= op1data.
  - 10: reg[op1] <= op1data and reg[15] <= r15data.
  - 11: reg[op1] <= op1data and reg[op2] <= op2data.
- Collision priority (same target, same cycle):
  - mode 11, op1 == op2: op1data wins; op2 write dropped.
  - mode 10, op1 == 4'hF: r15data wins.
- Read ports: rdDataX = pending write value if a write this cycle targets rdAddrX (same priority as above), else reg[rdAddrX]. r15Out follows the same rule for address 4'hF.
- wbCount: increments by 1 per committed cycle with rWrite != 00 (not per register written); wraps 16'hFFFF -> 16'h0000.

## Timing
- Writes commit on the rising edge of clk; new values visible from stored state in the following cycle, and via bypass in the same cycle.
- Read latency 0 (combinational from rdAddr and write inputs).
- Reset: rst_n low clears all 16 registers and wbCount to 0 immediately, without waiting for clk. While rst_n low: writes suppressed, bypass disabled, rdDataA = rdDataB = r15Out = 16'h0000, wbCount = 0.
- Reset asserted mid-operation discards any write of that cycle; no partial commit.
- First write commits on the first rising edge with rst_n high.
- Inputs must be stable around the rising edge; buffer outputs are registered, so no input registering here.
- No backpressure, no stall: every non-00 cycle commits.

## Test plan
- Reset: load reg[3]=16'h1234, pulse rst_n low between edges -> rdDataA(addr 3)=16'h0000 immediately, wbCount=0, no write on next edge if rst_n still low.
- Mode 01: rWrite=01, op1=4'h2, op1data=16'h00FF; rdAddrA=2 -> rdDataA=16'h00FF same cycle (bypass) and after edge; wbCount=1.
- Mode 10: rWrite=10, op1=4'h1, op1data=16'hCC00, r15data=16'h0090 -> reg[1]=16'hCC00, r15Out=16'h0090; then op1=4'hF, op1data=16'hAAAA, r15data=16'h5555 -> R15=16'h5555.
- Mode 11 collision: rWrite=11, op1=op2=4'h4, op1data=16'h0031, op2data=16'h0082 -> reg[4]=16'h0031; distinct op1=4, op2=5 -> both written, rdDataA/B reflect both.
- Mode 00: rWrite=00 with random op/data for 10 cycles -> all registers and wbCount unchanged.
- Counter wrap: drive 65536 non-00 cycles from reset -> wbCount returns to 16'h0000; one 00 cycle in between leaves it unchanged.
